// File: rtl/huffman_decoder.sv
// ============================================================================
// Module   : huffman_decoder
// Function : bit-serial Huffman decoder; rebuilds the 4-bit character buffer
//            from a packed bitstream and its code table.
// Option   : define HUFF_DEC_CYCLES_EN to add the 12-bit 'cycles' output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module huffman_decoder #(
  parameter int NUM_SYM = 5,
  parameter int ENTRY_W = 26,
  parameter int MAX_LEN = 15,
  parameter int BUF_W   = 1024
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       start,
  input  logic [NUM_SYM*ENTRY_W-1:0] CODE_TABLE,
  input  logic [BUF_W-1:0]           in,
  input  logic [10:0]                count,
  output logic [BUF_W-1:0]           character_out,
  output logic [8:0]                 num_chars,
  output logic                       busy,
  output logic                       done,
  output logic                       error
`ifdef HUFF_DEC_CYCLES_EN
  ,
  output logic [11:0]                cycles
`endif
);

  localparam int          IDX_W     = $clog2(BUF_W);
  localparam logic [3:0]  MAX_LEN_L = 4'(MAX_LEN);
  localparam logic [8:0]  MAX_CHARS = 9'(BUF_W / 4);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [BUF_W-1:0]           in_q, in_d;
  logic [10:0]                count_q, count_d;
  logic [NUM_SYM*ENTRY_W-1:0] table_q, table_d;
  // Stored accumulator is one bit short: a MAX_LEN-bit pattern never survives a cycle.
  logic [MAX_LEN-2:0]         acc_q, acc_d;
  logic [3:0]                 len_q, len_d;
  logic [10:0]                idx_q, idx_d;
  logic [BUF_W-1:0]           chars_q, chars_d;
  logic [8:0]                 num_q, num_d;
  logic                       err_q, err_d;
`ifdef HUFF_DEC_CYCLES_EN
  logic [11:0]                cyc_q, cyc_d;
`endif

  logic [MAX_LEN-1:0] acc_new;
  logic [3:0]         len_new;
  logic [ENTRY_W-1:0] ent;
  logic               hit;
  logic [3:0]         hit_sym;

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    count_d = count_q;
    table_d = table_q;
    acc_d   = acc_q;
    len_d   = len_q;
    idx_d   = idx_q;
    chars_d = chars_q;
    num_d   = num_q;
    err_d   = err_q;
    acc_new = '0;
    len_new = '0;
    ent     = '0;
    hit     = 1'b0;
    hit_sym = '0;
`ifdef HUFF_DEC_CYCLES_EN
    cyc_d   = cyc_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          in_d    = in;
          count_d = count;
          table_d = CODE_TABLE;
          chars_d = '0;
          num_d   = '0;
          err_d   = 1'b0;
          acc_d   = '0;
          len_d   = '0;
          idx_d   = '0;
          state_d = S_DECODE;
`ifdef HUFF_DEC_CYCLES_EN
          cyc_d   = '0;
`endif
        end
      end

      S_DECODE: begin
`ifdef HUFF_DEC_CYCLES_EN
        if (cyc_q != 12'hFFF) cyc_d = cyc_q + 12'd1;
`endif
        if (idx_q == count_q) begin
          if (len_q == 4'd0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end else begin
          acc_new = {acc_q, in_q[idx_q[IDX_W-1:0]]};
          len_new = len_q + 4'd1;
          idx_d   = idx_q + 11'd1;
          // Reverse-free priority: only the first matching entry is taken.
          for (int k = 0; k < NUM_SYM; k++) begin
            ent = table_q[k*ENTRY_W +: ENTRY_W];
            if (!hit && ent[21:18] != 4'd0 && ent[21:18] == len_new &&
                ent[17:0] == {{(18-MAX_LEN){1'b0}}, acc_new}) begin
              hit     = 1'b1;
              hit_sym = ent[25:22];
            end
          end
          if (hit) begin
            if (num_q == MAX_CHARS) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              chars_d[{num_q[7:0], 2'b00} +: 4] = hit_sym;
              num_d = num_q + 9'd1;
              acc_d = '0;
              len_d = '0;
            end
          end else if (len_new == MAX_LEN_L) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            acc_d = acc_new[MAX_LEN-2:0];
            len_d = len_new;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      in_q    <= '0;
      count_q <= '0;
      table_q <= '0;
      acc_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      chars_q <= '0;
      num_q   <= '0;
      err_q   <= 1'b0;
`ifdef HUFF_DEC_CYCLES_EN
      cyc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      count_q <= count_d;
      table_q <= table_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      chars_q <= chars_d;
      num_q   <= num_d;
      err_q   <= err_d;
`ifdef HUFF_DEC_CYCLES_EN
      cyc_q   <= cyc_d;
`endif
    end
  end

  assign character_out = chars_q;
  assign num_chars     = num_q;
  assign busy          = (state_q == S_DECODE);
  assign done          = (state_q == S_DONE);
  assign error         = err_q;
`ifdef HUFF_DEC_CYCLES_EN
  assign cycles        = cyc_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_huffman_decoder.sv
// ============================================================================
// Module   : tb_huffman_decoder
// Function : directed, table-driven self-checking bench for huffman_decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_huffman_decoder;

  localparam int NUM_SYM = 5;
  localparam int TW      = NUM_SYM * 26;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              start = 1'b0;
  logic [TW-1:0]     tbl = '0;
  logic [1023:0]     din = '0;
  logic [10:0]       cnt = '0;
  logic [1023:0]     character_out;
  logic [8:0]        num_chars;
  logic              busy, done, error;
`ifdef HUFF_DEC_CYCLES_EN
  logic [11:0]       cycles;
`endif

  huffman_decoder dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .start        (start),
    .CODE_TABLE   (tbl),
    .in           (din),
    .count        (cnt),
    .character_out(character_out),
    .num_chars    (num_chars),
    .busy         (busy),
    .done         (done),
    .error        (error)
`ifdef HUFF_DEC_CYCLES_EN
    ,
    .cycles       (cycles)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string         name;
    logic [TW-1:0] tbl;
    logic [1023:0] din;
    logic [10:0]   cnt;
    logic [8:0]    exp_num;
    logic [1023:0] exp_chars;
    logic          exp_err;
    int            exp_lat;   // edges after the accepting edge until done/error
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [25:0] ent(int sym, int len, int code);
    return {sym[3:0], len[3:0], code[17:0]};
  endfunction

  // Stream bits listed in transmission order; character i lands at in[i].
  function automatic logic [1023:0] bits(string s);
    logic [1023:0] r = '0;
    for (int i = 0; i < s.len(); i++) r[i] = (s[i] == "1");
    return r;
  endfunction

  task automatic chk(string nm, logic [1023:0] act, logic [1023:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h (low 64b) required %0h (low 64b)", nm, act[63:0], exp[63:0]);
    end
  endtask

  task automatic run_vec(vec_t v, bit inject);
    int n = 0;
    bit fin = 0;
    @(posedge CLK); #1;
    start = 1'b1; tbl = v.tbl; din = v.din; cnt = v.cnt;
    @(posedge CLK); #1;
    start = 1'b0;
    chk({v.name, " busy_after_start"}, 1024'(busy), 1024'(1));
    while (!fin && n < 2000) begin
      if (inject && n == 2) begin
        start = 1'b1; din = '1; cnt = 11'd0;
      end
      @(posedge CLK); #1;
      start = 1'b0;
      n++;
      if (done || error) fin = 1;
    end
    chk({v.name, " latency"}, 1024'(n), 1024'(v.exp_lat));
    chk({v.name, " error"}, 1024'(error), 1024'(v.exp_err));
    chk({v.name, " done"}, 1024'(done), 1024'(!v.exp_err));
    chk({v.name, " busy_end"}, 1024'(busy), 1024'(0));
    chk({v.name, " num_chars"}, 1024'(num_chars), 1024'(v.exp_num));
    chk({v.name, " chars"}, character_out, v.exp_chars);
`ifdef HUFF_DEC_CYCLES_EN
    chk({v.name, " cycles"}, 1024'(cycles), 1024'(v.exp_lat));
`endif
    @(posedge CLK); #1;
    chk({v.name, " done_one_cycle"}, 1024'(done), 1024'(0));
    chk({v.name, " error_hold"}, 1024'(error), 1024'(v.exp_err));
    chk({v.name, " num_hold"}, 1024'(num_chars), 1024'(v.exp_num));
  endtask

  logic [TW-1:0] common_t, only1_t, dup_t;
  vec_t basic_v, all_v;

  initial begin
    common_t = {ent(5,4,15), ent(4,4,14), ent(3,3,6), ent(2,2,2), ent(1,1,0)};
    only1_t  = {78'd0, ent(1,1,0)};
    dup_t    = {78'd0, ent(9,1,0), ent(7,1,0)};

    basic_v = '{"basic", common_t, bits("010110"), 11'd6, 9'd3,
                1024'h321, 1'b0, 7};
    all_v   = '{"all_syms", common_t, bits("01011011101111"), 11'd14, 9'd5,
                1024'h54321, 1'b0, 15};
    vecs.push_back(basic_v);
    vecs.push_back(all_v);
    vecs.push_back('{"count0", common_t, bits("0101"), 11'd0, 9'd0,
                     1024'h0, 1'b0, 1});
    vecs.push_back('{"truncated", common_t, bits("11"), 11'd2, 9'd0,
                     1024'h0, 1'b1, 3});
    vecs.push_back('{"after_err_ok", common_t, bits("010110"), 11'd6, 9'd3,
                     1024'h321, 1'b0, 7});
    vecs.push_back('{"unmatched", only1_t, bits("111111111111111"), 11'd15, 9'd0,
                     1024'h0, 1'b1, 15});
    vecs.push_back('{"beyond_count", common_t, bits("0111111"), 11'd1, 9'd1,
                     1024'h1, 1'b0, 2});
    vecs.push_back('{"priority", dup_t, bits("00"), 11'd2, 9'd2,
                     1024'h77, 1'b0, 3});
    vecs.push_back('{"five_five_one", common_t, bits("111111110"), 11'd9, 9'd3,
                     1024'h155, 1'b0, 10});
    vecs.push_back('{"partial_err", common_t, bits("0111"), 11'd4, 9'd1,
                     1024'h1, 1'b1, 5});
    vecs.push_back('{"overflow", common_t, 1024'h0, 11'd257, 9'd256,
                     {256{4'h1}}, 1'b1, 257});

    repeat (2) @(posedge CLK);
    #1;
    chk("reset busy", 1024'(busy), 1024'(0));
    chk("reset done", 1024'(done), 1024'(0));
    chk("reset error", 1024'(error), 1024'(0));
    chk("reset num", 1024'(num_chars), 1024'(0));
    chk("reset chars", character_out, 1024'h0);
    nRST = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], 1'b0);

    // Start pulse while busy must not disturb the running decode.
    run_vec('{"start_ignored", common_t, bits("010110"), 11'd6, 9'd3,
              1024'h321, 1'b0, 7}, 1'b1);

    // Asynchronous reset in the middle of the 14-bit decode.
    @(posedge CLK); #1;
    start = 1'b1; tbl = common_t; din = all_v.din; cnt = all_v.cnt;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("mid num_nonzero", 1024'(num_chars != 0), 1024'(1));
    nRST = 1'b0;
    #1;
    chk("midrst busy", 1024'(busy), 1024'(0));
    chk("midrst done", 1024'(done), 1024'(0));
    chk("midrst error", 1024'(error), 1024'(0));
    chk("midrst num", 1024'(num_chars), 1024'(0));
    chk("midrst chars", character_out, 1024'h0);
    @(posedge CLK); #1;
    chk("midrst no_done", 1024'(done), 1024'(0));
    nRST = 1'b1;
    run_vec(all_v, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
- Receive-side counterpart of the Huffman encoder output stage: accepts the packed encoded bitstream, its valid bit count and the same code table, and reconstructs the 4-bit character stream.
- Sits after the encoder (or after a channel/loopback) and produces a character buffer in the same packing the encoder consumes, for round-trip checking.
- Decoding is bit-serial: one stream bit per clock, matched in parallel against all table entries.

Parameters:
- NUM_SYM, 5, number of code-table entries.
- ENTRY_W, 26, bits per table entry.
- MAX_LEN, 15, longest legal codeword in bits.
- BUF_W, 1024, width of the bitstream and character buffers.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; captures in, count and CODE_TABLE.
- CODE_TABLE  in  NUM_SYM*ENTRY_W  entry k at bits [k*26+25 : k*26].
- in  in  BUF_W  encoded bitstream; first transmitted bit at in[0], ascending.
- count  in  11  number of valid stream bits, 0..1024.
- character_out  out  BUF_W  decoded characters; char i at [4i+3:4i]; unused nibbles 0.
- num_chars  out  9  characters decoded, 0..256.
- busy  out  1  high while decoding.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky decode error; cleared by next accepted start.

Behaviour:
- Entry format: [25:22] symbol; [21:18] code length L (0 = entry unused); [17:0] codeword right-aligned, MSB transmitted first; bits above L are zero.
- Reset (async, nRST=0): state IDLE; character_out=0, num_chars=0, busy=0, done=0, error=0; internal accumulator, length and bit index cleared.
- IDLE:
  - start=1 at an edge: capture in, count and CODE_TABLE into registers.
  - Clear character_out, num_chars, error and accumulator; bit index = 0.
  - Go to DECODE; busy=1 from the next cycle.
  - start is ignored outside IDLE.
- DECODE, one bit per edge:
  - acc = {acc, in_r[idx]}; len = len+1; idx = idx+1.
  - If some valid entry has L == new len and code == new acc: write its symbol at nibble num_chars, increment num_chars, clear acc and len. The lowest-index entry wins on multiple matches.
- DECODE exits:
  - idx reaches count with len==0: go to DONE.
  - New len == MAX_LEN with no match: ERR.
  - idx reaches count with len != 0 (truncated codeword): ERR.
  - A match when num_chars == 256 (overflow): ERR; buffer unchanged.
- count=0: first DECODE edge goes to DONE with num_chars=0.
- Bits beyond count are never read.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. Outputs hold until the next start.
- ERR: error=1, busy=0; go to IDLE on the next edge. error stays high; num_chars and character_out keep the chars decoded so far.
- Latency: start sampled at edge E0; done high after edge E(count+1); total count+2 cycles, start to IDLE.
- Reset mid-operation aborts immediately to the reset values; no partial done.

Optional Feature:
- Macro HUFF_DEC_CYCLES_EN.
- Defined: extra output cycles [11:0]. Cleared on accepted start; increments each cycle in DECODE; saturates at 4095; holds after DONE/ERR; reset 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Common table: sym1="0"(L1), sym2="10"(L2), sym3="110"(L3), sym4="1110"(L4), sym5="1111"(L4).
- Basic decode: in[5:0]=6'b011010 (stream 0,1,0,1,1,0), count=6, start pulse -> after 7 edges done=1 one cycle, num_chars=3, character_out[11:0]=12'h321, rest 0, error=0.
- All symbols: stream for 1,2,3,4,5, count=14 -> num_chars=5, character_out[19:0]=20'h54321, done 15 edges after start.
- count=0 -> done after one DECODE edge, num_chars=0, character_out=0.
- Truncated codeword: stream "1,1" with count=2 -> error=1, done never pulses, num_chars=0; next valid start clears error.
- Unmatched code: table with only sym1="0", stream of 15 ones, count=15 -> error=1 after 15 DECODE edges.
- Reset mid-decode: nRST low during DECODE of the 14-bit case -> all outputs 0 immediately; after release the same start decodes correctly; start pulses while busy are ignored.
